// File: rtl/aes_dma_pkg.sv
// Shared types and constants for the AES DMA copy engine.
// Optional build macro AES_DMA_TIMEOUT_EN enables the poll watchdog in aes_dma.
package aes_dma_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_RD,
    LOAD_WR,
    KICK,
    POLL,
    ST_RD,
    ST_WR,
    DONE,
    ERR
  } dma_state_e;

  // Default parameter values for the top level
  localparam int unsigned MAX_WORDS_DEF      = 256;
  localparam logic [31:0] AES_BUF_BASE_DEF   = 32'h0004_0000;
  localparam logic [31:0] AES_CTRL_ADDR_DEF  = 32'h0004_0300;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 65536;

  // MMIO window and register offsets
  localparam logic [3:0] DMA_WINDOW = 4'h5;
  localparam logic [7:0] OFF_SRC    = 8'h00;
  localparam logic [7:0] OFF_DST    = 8'h04;
  localparam logic [7:0] OFF_LEN    = 8'h08;
  localparam logic [7:0] OFF_CTRL   = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;

  // CTRL register bits
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_MODE_BIT  = 1;

  // STATUS register bits
  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_DONE_BIT    = 1;
  localparam int unsigned STAT_ERR_BIT     = 2;
  localparam int unsigned STAT_TIMEOUT_BIT = 3;

  // AES coprocessor control/status bits
  localparam int unsigned AES_ENC_BIT   = 0;
  localparam int unsigned AES_DEC_BIT   = 1;
  localparam int unsigned AES_VALID_BIT = 2;

  // Control word that starts the coprocessor: decrypt when mode is 1, else encrypt
  function automatic logic [31:0] aes_ctrl_word(input logic mode);
    logic [31:0] w;
    w              = '0;
    w[AES_DEC_BIT] = mode;
    w[AES_ENC_BIT] = ~mode;
    return w;
  endfunction

endpackage

// File: rtl/aes_dma_regs.sv
// MMIO register file for the AES DMA: address decode, SRC/DST/LEN/CTRL storage,
// sticky status flags and the combinational read mux.
module aes_dma_regs
  import aes_dma_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_addr_in,
  input  logic [31:0] cpu_data_in,
  input  logic [3:0]  cpu_write_enable_in,
  output logic [31:0] cpu_data_out,
  input  logic        busy_in,
  input  logic        idle_in,
  input  logic        set_done_in,
  input  logic        set_err_in,
  input  logic        set_timeout_in,
  output logic [31:0] src_out,
  output logic [31:0] dst_out,
  output logic [31:0] len_out,
  output logic        mode_out,
  output logic        start_out
);

  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] len_q, len_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        timeout_q, timeout_d;

  logic        sel;
  logic        wr;
  logic [7:0]  off;
  logic [11:0] unused_addr_hi;

  assign unused_addr_hi = cpu_addr_in[31:20];
  assign off            = cpu_addr_in[7:0];
  assign sel            = (cpu_addr_in[19:16] == DMA_WINDOW) && (cpu_addr_in[15:8] == 8'h00);
  assign wr             = sel && (cpu_write_enable_in == 4'hF);
  // START only launches from IDLE; DONE/ERR cycles are not busy but still reject it
  assign start_out      = wr && (off == OFF_CTRL) && cpu_data_in[CTRL_START_BIT] && idle_in;

  assign src_out  = src_q;
  assign dst_out  = dst_q;
  assign len_out  = len_q;
  assign mode_out = mode_q;

  // Next-state for the register file and sticky status flags
  always_comb begin
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    mode_d    = mode_q;
    done_d    = done_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    if (wr && !busy_in) begin
      case (off)
        OFF_SRC:  src_d  = {cpu_data_in[31:2], 2'b00};
        OFF_DST:  dst_d  = {cpu_data_in[31:2], 2'b00};
        OFF_LEN:  len_d  = cpu_data_in;
        OFF_CTRL: mode_d = cpu_data_in[CTRL_MODE_BIT];
        default:  ;
      endcase
    end
    if (start_out) begin
      done_d    = 1'b0;
      err_d     = 1'b0;
      timeout_d = 1'b0;
    end
    if (set_done_in)    done_d    = 1'b1;
    if (set_err_in)     err_d     = 1'b1;
    if (set_timeout_in) timeout_d = 1'b1;
  end

  // Register storage with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  // Combinational read mux; START always reads back as 0
  always_comb begin
    cpu_data_out = '0;
    if (sel) begin
      case (off)
        OFF_SRC:    cpu_data_out = src_q;
        OFF_DST:    cpu_data_out = dst_q;
        OFF_LEN:    cpu_data_out = len_q;
        OFF_CTRL:   cpu_data_out[CTRL_MODE_BIT] = mode_q;
        OFF_STATUS: begin
          cpu_data_out[STAT_BUSY_BIT]    = busy_in;
          cpu_data_out[STAT_DONE_BIT]    = done_q;
          cpu_data_out[STAT_ERR_BIT]     = err_q;
          cpu_data_out[STAT_TIMEOUT_BIT] = timeout_q;
        end
        default:    cpu_data_out = '0;
      endcase
    end
  end

endmodule

// File: rtl/aes_dma.sv
// AES DMA copy engine: loads N words into the AES buffer, kicks the coprocessor,
// polls for a valid result and copies the result back to main memory.
// Build macro AES_DMA_TIMEOUT_EN adds a poll watchdog (TIMEOUT_CYCLES).
//
// state   | meaning
// IDLE    | waiting for START; all bus outputs 0
// LOAD_RD | read main memory at SRC+4*i
// LOAD_WR | write returned word to AES buffer word i, i++
// KICK    | write encrypt/decrypt command to AES control register
// POLL    | read AES control register until valid_result
// ST_RD   | read AES buffer word i
// ST_WR   | write returned word to main memory at DST+4*i, i++
// DONE    | set done, pulse irq
// ERR     | set err (and timeout, after abort write), pulse irq
module aes_dma
  import aes_dma_pkg::*;
#(
  parameter int unsigned MAX_WORDS      = MAX_WORDS_DEF,
  parameter logic [31:0] AES_BUF_BASE   = AES_BUF_BASE_DEF,
  parameter logic [31:0] AES_CTRL_ADDR  = AES_CTRL_ADDR_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_addr_in,
  input  logic [31:0] cpu_data_in,
  input  logic [3:0]  cpu_write_enable_in,
  output logic [31:0] cpu_data_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  mem_we_out,
  input  logic [31:0] mem_data_in,
  output logic [31:0] aes_addr_out,
  output logic [31:0] aes_data_out,
  output logic [3:0]  aes_we_out,
  input  logic [31:0] aes_data_in,
  output logic        busy_out,
  output logic        irq_out
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  dma_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  // aes_data_in only reflects a POLL read one cycle after POLL issued it
  logic             poll_rsp_q, poll_rsp_d;

  logic [31:0] src, dst, len;
  logic        mode, start;
  logic        len_bad, last_word;
  logic        set_done, set_err, set_timeout;

`ifdef AES_DMA_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit_q, tmo_hit_d;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  aes_dma_regs u_regs (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .cpu_addr_in         (cpu_addr_in),
    .cpu_data_in         (cpu_data_in),
    .cpu_write_enable_in (cpu_write_enable_in),
    .cpu_data_out        (cpu_data_out),
    .busy_in             (busy_out),
    .idle_in             (state_q == IDLE),
    .set_done_in         (set_done),
    .set_err_in          (set_err),
    .set_timeout_in      (set_timeout),
    .src_out             (src),
    .dst_out             (dst),
    .len_out             (len),
    .mode_out            (mode),
    .start_out           (start)
  );

  assign idx_nxt   = idx_q + 1'b1;
  assign last_word = (32'(idx_nxt) == len);
  assign len_bad   = (len == '0) || (len > 32'(MAX_WORDS));
  assign busy_out  = !(state_q inside {IDLE, DONE, ERR});

  // Next-state, index/timer update and bus outputs
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    poll_rsp_d   = (state_q == POLL);
    mem_addr_out = '0;
    mem_data_out = '0;
    mem_we_out   = '0;
    aes_addr_out = '0;
    aes_data_out = '0;
    aes_we_out   = '0;
    irq_out      = 1'b0;
    set_done     = 1'b0;
    set_err      = 1'b0;
    set_timeout  = 1'b0;
`ifdef AES_DMA_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tmo_hit_d    = tmo_hit_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = len_bad ? ERR : LOAD_RD;
        end
      end
      LOAD_RD: begin
        mem_addr_out = src + (32'(idx_q) << 2);
        state_d      = LOAD_WR;
      end
      LOAD_WR: begin
        aes_addr_out = AES_BUF_BASE + 32'(idx_q);
        aes_data_out = mem_data_in;
        aes_we_out   = 4'hF;
        idx_d        = idx_nxt;
        state_d      = last_word ? KICK : LOAD_RD;
      end
      KICK: begin
        aes_addr_out = AES_CTRL_ADDR;
        aes_data_out = aes_ctrl_word(mode);
        aes_we_out   = 4'hF;
        idx_d        = '0;
        state_d      = POLL;
`ifdef AES_DMA_TIMEOUT_EN
        tmo_cnt_d    = TMO_W'(TIMEOUT_CYCLES - 1);
`endif
      end
      POLL: begin
        aes_addr_out = AES_CTRL_ADDR;
        if (poll_rsp_q && aes_data_in[AES_VALID_BIT]) begin
          state_d = ST_RD;
        end
`ifdef AES_DMA_TIMEOUT_EN
        else if (tmo_cnt_q == '0) begin
          tmo_hit_d = 1'b1;
          state_d   = ERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 1'b1;
        end
`endif
      end
      ST_RD: begin
        aes_addr_out = AES_BUF_BASE + 32'(idx_q);
        state_d      = ST_WR;
      end
      ST_WR: begin
        mem_addr_out = dst + (32'(idx_q) << 2);
        mem_data_out = aes_data_in;
        mem_we_out   = 4'hF;
        idx_d        = idx_nxt;
        state_d      = last_word ? DONE : ST_RD;
      end
      DONE: begin
        irq_out  = 1'b1;
        set_done = 1'b1;
        state_d  = IDLE;
      end
      ERR: begin
        irq_out = 1'b1;
        set_err = 1'b1;
        state_d = IDLE;
`ifdef AES_DMA_TIMEOUT_EN
        // Watchdog expiry: cancel the coprocessor operation before reporting
        if (tmo_hit_q) begin
          aes_addr_out = AES_CTRL_ADDR;
          aes_data_out = '0;
          aes_we_out   = 4'hF;
          set_timeout  = 1'b1;
          tmo_hit_d    = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index and watchdog registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      poll_rsp_q <= 1'b0;
`ifdef AES_DMA_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      tmo_hit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      poll_rsp_q <= poll_rsp_d;
`ifdef AES_DMA_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_hit_q  <= tmo_hit_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_dma.sv
// Directed testbench for aes_dma with a main-memory model and an AES coprocessor stub.
module tb_aes_dma;

  localparam logic [31:0] BUF_BASE  = 32'h0004_0000;
  localparam logic [31:0] CTRL_ADDR = 32'h0004_0300;
  localparam logic [31:0] DMA_BASE  = 32'h0005_0000;
  localparam logic [31:0] KEY_ENC   = 32'h5A5A_0F0F;
  localparam logic [31:0] KEY_DEC   = 32'hC3C3_1234;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_addr_in, cpu_data_in, cpu_data_out;
  logic [3:0]  cpu_write_enable_in;
  logic [31:0] mem_addr_out, mem_data_out, mem_data_in;
  logic [3:0]  mem_we_out;
  logic [31:0] aes_addr_out, aes_data_out, aes_data_in;
  logic [3:0]  aes_we_out;
  logic        busy_out, irq_out;

  int errors = 0;
  int checks = 0;

  aes_dma #(
    .MAX_WORDS      (256),
    .AES_BUF_BASE   (BUF_BASE),
    .AES_CTRL_ADDR  (CTRL_ADDR),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .cpu_addr_in         (cpu_addr_in),
    .cpu_data_in         (cpu_data_in),
    .cpu_write_enable_in (cpu_write_enable_in),
    .cpu_data_out        (cpu_data_out),
    .mem_addr_out        (mem_addr_out),
    .mem_data_out        (mem_data_out),
    .mem_we_out          (mem_we_out),
    .mem_data_in         (mem_data_in),
    .aes_addr_out        (aes_addr_out),
    .aes_data_out        (aes_data_out),
    .aes_we_out          (aes_we_out),
    .aes_data_in         (aes_data_in),
    .busy_out            (busy_out),
    .irq_out             (irq_out)
  );

  always #5 clk_in = ~clk_in;

  // Unwritten memory words hold a fixed pattern derived from their word index
  function automatic logic [31:0] pat(input int idx);
    return 32'hA500_0000 + (32'(idx) * 32'h0001_0003);
  endfunction

  // Main memory: registered read, full-word writes
  logic [31:0] mem [0:8191];
  bit          mem_written [0:8191];
  int          mem_wr_cnt = 0;
  always @(posedge clk_in) begin
    if (mem_we_out != 4'h0) mem_wr_cnt <= mem_wr_cnt + 1;
    if (mem_we_out == 4'hF) begin
      mem[mem_addr_out[14:2]]         <= mem_data_out;
      mem_written[mem_addr_out[14:2]] <= 1'b1;
    end
    mem_data_in <= mem_written[mem_addr_out[14:2]] ? mem[mem_addr_out[14:2]] : pat(int'(mem_addr_out[14:2]));
  end

  function automatic logic [31:0] mem_rd(input int idx);
    return mem_written[idx] ? mem[idx] : pat(idx);
  endfunction

  // AES stub: result = input XOR key, valid 10 cycles after a start command
  logic [31:0] aes_in  [0:255];
  logic [31:0] aes_out [0:255];
  logic        aes_valid   = 1'b0;
  logic [1:0]  aes_mode_q  = 2'b00;
  int          aes_cnt     = 0;
  bit          never_valid = 1'b0;
  int          ctrl_wr_cnt = 0;
  logic [31:0] ctrl_last   = '0;
  int          aes_wr_cnt  = 0;
  int          poll_cnt    = 0;
  int          irq_cnt     = 0;
  always @(posedge clk_in) begin
    if (aes_we_out != 4'h0) aes_wr_cnt <= aes_wr_cnt + 1;
    if (aes_we_out == 4'hF) begin
      if (aes_addr_out == CTRL_ADDR) begin
        ctrl_wr_cnt <= ctrl_wr_cnt + 1;
        ctrl_last   <= aes_data_out;
        aes_mode_q  <= aes_data_out[1:0];
        aes_valid   <= 1'b0;
        aes_cnt     <= (aes_data_out[1:0] != 2'b00) ? 10 : 0;
      end else if (aes_addr_out[31:8] == BUF_BASE[31:8]) begin
        aes_in[aes_addr_out[7:0]] <= aes_data_out;
      end
    end else if (aes_cnt > 0) begin
      aes_cnt <= aes_cnt - 1;
      if (aes_cnt == 1 && !never_valid) begin
        aes_valid <= 1'b1;
        for (int k = 0; k < 256; k++) aes_out[k] <= aes_in[k] ^ (aes_mode_q[1] ? KEY_DEC : KEY_ENC);
      end
    end
    if (aes_addr_out == CTRL_ADDR) aes_data_in <= {29'b0, aes_valid, aes_mode_q};
    else if (aes_addr_out[31:8] == BUF_BASE[31:8])
      aes_data_in <= aes_valid ? aes_out[aes_addr_out[7:0]] : aes_in[aes_addr_out[7:0]];
    else aes_data_in <= '0;
    if (aes_addr_out == CTRL_ADDR && aes_we_out == 4'h0) poll_cnt <= poll_cnt + 1;
    if (irq_out) irq_cnt <= irq_cnt + 1;
  end

  task automatic cpu_wr(input logic [7:0] off, input logic [31:0] d);
    @(negedge clk_in);
    cpu_addr_in         = DMA_BASE | 32'(off);
    cpu_data_in         = d;
    cpu_write_enable_in = 4'hF;
    @(negedge clk_in);
    cpu_write_enable_in = 4'h0;
  endtask

  task automatic cpu_rd(input logic [7:0] off, output logic [31:0] d);
    cpu_addr_in = DMA_BASE | 32'(off);
    #1 d = cpu_data_out;
  endtask

  task automatic wait_irq(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge clk_in);
      if (irq_out) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checks++;
    if ({mem_addr_out, mem_data_out, mem_we_out, aes_addr_out, aes_data_out, aes_we_out, busy_out, irq_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got mem_addr=%h aes_addr=%h mem_we=%h aes_we=%h busy=%b irq=%b expected all 0",
               mem_addr_out, aes_addr_out, mem_we_out, aes_we_out, busy_out, irq_out);
    end
    cpu_rd(8'h10, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got=%h expected=%h", rd, 32'h0); end
    cpu_rd(8'h08, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_len got=%h expected=%h", rd, 32'h0); end
    rst_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_basic;
    int c0, i0;
    bit seen;
    logic [31:0] rd;
    c0 = ctrl_wr_cnt;
    i0 = irq_cnt;
    cpu_wr(8'h00, 32'h0000_1000);
    cpu_wr(8'h04, 32'h0000_2000);
    cpu_wr(8'h08, 32'd4);
    cpu_wr(8'h0C, 32'h1);
    checks++;
    if (busy_out !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b expected=1", busy_out); end
    wait_irq(200, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL basic_irq_timeout got=no_irq expected=irq"); end
    repeat (3) @(negedge clk_in);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (aes_in[k] !== pat(32'h400 + k)) begin
        errors++; $display("FAIL basic_aesbuf[%0d] got=%h expected=%h", k, aes_in[k], pat(32'h400 + k));
      end
      checks++;
      if (mem_rd(32'h800 + k) !== (pat(32'h400 + k) ^ KEY_ENC)) begin
        errors++; $display("FAIL basic_dst[%0d] got=%h expected=%h", k, mem_rd(32'h800 + k), pat(32'h400 + k) ^ KEY_ENC);
      end
    end
    checks++;
    if (ctrl_wr_cnt - c0 !== 1) begin errors++; $display("FAIL basic_ctrl_writes got=%0d expected=1", ctrl_wr_cnt - c0); end
    checks++;
    if (ctrl_last !== 32'h1) begin errors++; $display("FAIL basic_ctrl_data got=%h expected=%h", ctrl_last, 32'h1); end
    cpu_rd(8'h10, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL basic_status got=%h expected=%h", rd, 32'h2); end
    checks++;
    if (irq_cnt - i0 !== 1) begin errors++; $display("FAIL basic_irq_count got=%0d expected=1", irq_cnt - i0); end
  endtask

  task automatic test_len_err;
    logic [31:0] lens [2];
    logic [31:0] rd;
    int m0, a0, i0;
    lens[0] = 32'd0;
    lens[1] = 32'd257;
    for (int t = 0; t < 2; t++) begin
      m0 = mem_wr_cnt;
      a0 = aes_wr_cnt;
      i0 = irq_cnt;
      cpu_wr(8'h08, lens[t]);
      cpu_wr(8'h0C, 32'h1);
      checks++;
      if (irq_out !== 1'b1) begin errors++; $display("FAIL lenerr_irq len=%0d got=%b expected=1", lens[t], irq_out); end
      repeat (2) @(negedge clk_in);
      cpu_rd(8'h10, rd);
      checks++;
      if (rd !== 32'h4) begin errors++; $display("FAIL lenerr_status len=%0d got=%h expected=%h", lens[t], rd, 32'h4); end
      checks++;
      if ((mem_wr_cnt - m0) !== 0 || (aes_wr_cnt - a0) !== 0) begin
        errors++; $display("FAIL lenerr_writes len=%0d got mem=%0d aes=%0d expected 0 0", lens[t], mem_wr_cnt - m0, aes_wr_cnt - a0);
      end
      checks++;
      if (irq_cnt - i0 !== 1) begin errors++; $display("FAIL lenerr_irq_count len=%0d got=%0d expected=1", lens[t], irq_cnt - i0); end
    end
  endtask

  task automatic test_decrypt;
    bit seen;
    logic [31:0] rd;
    cpu_wr(8'h00, 32'h0000_1100);
    cpu_wr(8'h04, 32'h0000_2400);
    cpu_wr(8'h08, 32'd1);
    cpu_wr(8'h0C, 32'h3);
    wait_irq(200, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL dec_irq_timeout got=no_irq expected=irq"); end
    repeat (2) @(negedge clk_in);
    checks++;
    if (ctrl_last !== 32'h2) begin errors++; $display("FAIL dec_ctrl_data got=%h expected=%h", ctrl_last, 32'h2); end
    checks++;
    if (mem_rd(32'h900) !== (pat(32'h440) ^ KEY_DEC)) begin
      errors++; $display("FAIL dec_dst got=%h expected=%h", mem_rd(32'h900), pat(32'h440) ^ KEY_DEC);
    end
    cpu_rd(8'h10, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL dec_status got=%h expected=%h", rd, 32'h2); end
    cpu_rd(8'h0C, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL dec_ctrl_readback got=%h expected=%h", rd, 32'h2); end
  endtask

  task automatic test_busy_writes;
    int c0, i0;
    bit seen;
    logic [31:0] rd;
    cpu_wr(8'h00, 32'h0000_1000);
    cpu_wr(8'h04, 32'h0000_3000);
    cpu_wr(8'h08, 32'd4);
    c0 = ctrl_wr_cnt;
    i0 = irq_cnt;
    cpu_wr(8'h0C, 32'h1);
    cpu_wr(8'h00, 32'h0000_5000);
    cpu_wr(8'h08, 32'd2);
    cpu_wr(8'h0C, 32'h3);
    checks++;
    if (busy_out !== 1'b1) begin errors++; $display("FAIL busy_still_busy got=%b expected=1", busy_out); end
    wait_irq(200, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL busy_irq_timeout got=no_irq expected=irq"); end
    repeat (3) @(negedge clk_in);
    cpu_rd(8'h00, rd);
    checks++;
    if (rd !== 32'h0000_1000) begin errors++; $display("FAIL busy_src got=%h expected=%h", rd, 32'h0000_1000); end
    cpu_rd(8'h08, rd);
    checks++;
    if (rd !== 32'd4) begin errors++; $display("FAIL busy_len got=%h expected=%h", rd, 32'd4); end
    cpu_rd(8'h0C, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL busy_mode got=%h expected=%h", rd, 32'h0); end
    checks++;
    if (ctrl_wr_cnt - c0 !== 1) begin errors++; $display("FAIL busy_ctrl_writes got=%0d expected=1", ctrl_wr_cnt - c0); end
    checks++;
    if (irq_cnt - i0 !== 1) begin errors++; $display("FAIL busy_irq_count got=%0d expected=1", irq_cnt - i0); end
    checks++;
    if (mem_rd(32'hC03) !== (pat(32'h403) ^ KEY_ENC)) begin
      errors++; $display("FAIL busy_dst_last got=%h expected=%h", mem_rd(32'hC03), pat(32'h403) ^ KEY_ENC);
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    int c0, i0;
    logic [31:0] rd;
    cpu_wr(8'h00, 32'h0000_1000);
    cpu_wr(8'h04, 32'h0000_3800);
    cpu_wr(8'h08, 32'd4);
    cpu_wr(8'h0C, 32'h1);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (aes_we_out == 4'hF && aes_addr_out == BUF_BASE + 32'd2) found = 1'b1;
      else @(negedge clk_in);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rstmid_find_i2 got=not_found expected=found"); end
    c0 = ctrl_wr_cnt;
    i0 = irq_cnt;
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({mem_addr_out, mem_data_out, mem_we_out, aes_addr_out, aes_data_out, aes_we_out, busy_out, irq_out} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got mem_addr=%h aes_addr=%h mem_we=%h aes_we=%h busy=%b irq=%b expected all 0",
               mem_addr_out, aes_addr_out, mem_we_out, aes_we_out, busy_out, irq_out);
    end
    cpu_rd(8'h10, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rstmid_status got=%h expected=%h", rd, 32'h0); end
    rst_in = 1'b0;
    repeat (20) @(negedge clk_in);
    checks++;
    if ((ctrl_wr_cnt - c0) !== 0 || (irq_cnt - i0) !== 0 || busy_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet got ctrl=%0d irq=%0d busy=%b expected 0 0 0", ctrl_wr_cnt - c0, irq_cnt - i0, busy_out);
    end
  endtask

`ifdef AES_DMA_TIMEOUT_EN
  task automatic test_timeout;
    int c0, i0, p0, m0;
    bit seen;
    logic [31:0] rd;
    never_valid = 1'b1;
    cpu_wr(8'h00, 32'h0000_1000);
    cpu_wr(8'h04, 32'h0000_3400);
    cpu_wr(8'h08, 32'd1);
    c0 = ctrl_wr_cnt;
    i0 = irq_cnt;
    p0 = poll_cnt;
    m0 = mem_wr_cnt;
    cpu_wr(8'h0C, 32'h1);
    wait_irq(200, seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL tmo_irq_timeout got=no_irq expected=irq"); end
    repeat (3) @(negedge clk_in);
    checks++;
    if (poll_cnt - p0 !== 16) begin errors++; $display("FAIL tmo_poll_cycles got=%0d expected=16", poll_cnt - p0); end
    checks++;
    if (ctrl_wr_cnt - c0 !== 2) begin errors++; $display("FAIL tmo_ctrl_writes got=%0d expected=2", ctrl_wr_cnt - c0); end
    checks++;
    if (ctrl_last !== 32'h0) begin errors++; $display("FAIL tmo_ctrl_data got=%h expected=%h", ctrl_last, 32'h0); end
    cpu_rd(8'h10, rd);
    checks++;
    if (rd !== 32'hC) begin errors++; $display("FAIL tmo_status got=%h expected=%h", rd, 32'hC); end
    checks++;
    if (irq_cnt - i0 !== 1) begin errors++; $display("FAIL tmo_irq_count got=%0d expected=1", irq_cnt - i0); end
    checks++;
    if (mem_wr_cnt - m0 !== 0) begin errors++; $display("FAIL tmo_mem_writes got=%0d expected=0", mem_wr_cnt - m0); end
    never_valid = 1'b0;
  endtask
`endif

  initial begin
    rst_in              = 1'b1;
    cpu_addr_in         = '0;
    cpu_data_in         = '0;
    cpu_write_enable_in = 4'h0;
    test_reset;
    test_basic;
    test_len_err;
    test_decrypt;
    test_busy_writes;
    test_reset_mid;
`ifdef AES_DMA_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog got=still_running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
